// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access pipeline stage.
//   - funct3 access-size encodings for loads and stores
//   - FSM state encoding
//   - default abort timeout and the MEM/WB register layout
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic        enable;
        logic        memtoreg;
        logic        regwrite;
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [4:0]  rd;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_load_store_align.sv
// Combinational lane logic for the memory stage.
//   i_funct3     access size/sign
//   i_is_store   1 for a store, 0 for a load
//   i_addr_lo    byte offset within the word
//   i_wd         store data (unaligned, low lanes)
//   i_rdata      raw read word from memory
//   o_misaligned access cannot be issued
//   o_wstrb      byte strobes (0 for loads)
//   o_wdata      lane-replicated store data
//   o_load_data  extracted and extended load result
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wd,
    input  logic [31:0] i_rdata,
    output logic        o_misaligned,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_strb;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        o_misaligned = 1'b1;
        w_strb       = 4'b0000;
        o_wdata      = i_wd;
        o_load_data  = i_rdata;
        case (i_funct3)
            F3_B: begin
                o_misaligned = 1'b0;
                w_strb       = 4'b0001 << i_addr_lo;
                o_wdata      = {4{i_wd[7:0]}};
                o_load_data  = {{24{w_byte[7]}}, w_byte};
            end
            F3_BU: begin
                // Unsigned encodings have no store counterpart.
                o_misaligned = i_is_store;
                o_load_data  = {24'd0, w_byte};
            end
            F3_H: begin
                o_misaligned = i_addr_lo[0];
                w_strb       = 4'b0011 << i_addr_lo;
                o_wdata      = {2{i_wd[15:0]}};
                o_load_data  = {{16{w_half[15]}}, w_half};
            end
            F3_HU: begin
                o_misaligned = i_is_store || i_addr_lo[0];
                o_load_data  = {16'd0, w_half};
            end
            F3_W: begin
                o_misaligned = (i_addr_lo != 2'b00);
                w_strb       = 4'b1111;
            end
            default: o_misaligned = 1'b1;
        endcase
        o_wstrb = i_is_store ? w_strb : 4'b0000;
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: turns EX/MEM contents into valid/ready
// data-memory requests, aligns store lanes and extends load data, and
// produces the MEM/WB register. mem_stall holds upstream during an access;
// an access that runs TIMEOUT_CYCLES cycles in REQ+WAIT is aborted.
//   clk, reset           clock, async active-high reset
//   EX_MEM_*             incoming instruction fields and control
//   dmem_req_* / dmem_*  registered request channel; rsp_valid/rdata in
//   mem_stall            combinational stall to the hazard unit
//   mem_misaligned       one-cycle pulse for a misaligned access
//   mem_bus_error        one-cycle pulse for a timed-out access
//   MEM_WB_*             registered MEM/WB pipeline register
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_MEM_enable_out,
    input  logic [31:0] EX_MEM_PC,
    input  logic [31:0] EX_MEM_ALUResult,
    input  logic [31:0] EX_MEM_WriteData,
    input  logic [4:0]  EX_MEM_Rd,
    input  logic [2:0]  EX_MEM_Funct3,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic        EX_MEM_MemToReg,
    input  logic        EX_MEM_RegWrite,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_misaligned,
    output logic        mem_bus_error,
    output logic        MEM_WB_enable_out,
    output logic        MEM_WB_MemToReg,
    output logic        MEM_WB_RegWrite,
    output logic [31:0] MEM_WB_PC,
    output logic [31:0] MEM_WB_ALUResult,
    output logic [31:0] MEM_WB_ReadData,
    output logic [4:0]  MEM_WB_Rd
);

    localparam logic [15:0] LP_COUNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_next_state;
    logic [15:0] r_count;

    // Instruction fields captured when the access starts.
    logic [31:0] r_pc, r_alu;
    logic [4:0]  r_rd;
    logic [2:0]  r_funct3;
    logic        r_memtoreg, r_regwrite;

    logic        r_req_valid, r_we;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    mem_wb_t     r_mem_wb;
    logic        r_misaligned, r_bus_error;

    logic        w_idle, w_mem_op, w_misaligned, w_complete, w_timeout;
    logic [2:0]  w_funct3;
    logic        w_is_store;
    logic [1:0]  w_addr_lo;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata, w_load_data;

    assign w_idle   = (r_state == S_IDLE);
    assign w_mem_op = EX_MEM_enable_out && (EX_MEM_MemRead || EX_MEM_MemWrite);

    // The lane unit sees the live instruction in IDLE (alignment, store lanes)
    // and the captured one during the access (load extraction).
    assign w_funct3   = w_idle ? EX_MEM_Funct3 : r_funct3;
    assign w_is_store = w_idle ? EX_MEM_MemWrite : r_we;
    assign w_addr_lo  = w_idle ? EX_MEM_ALUResult[1:0] : r_alu[1:0];

    load_store_align u_align (
        .i_funct3     (w_funct3),
        .i_is_store   (w_is_store),
        .i_addr_lo    (w_addr_lo),
        .i_wd         (EX_MEM_WriteData),
        .i_rdata      (dmem_rdata),
        .o_misaligned (w_misaligned),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        mem_stall    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op && !w_misaligned) begin
                    mem_stall    = 1'b1;
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (r_count == LP_COUNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    if (dmem_req_ready) w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response in the last allowed cycle still completes.
                if (dmem_rsp_valid) begin
                    w_complete   = 1'b1;
                    w_next_state = S_IDLE;
                end else if (r_count == LP_COUNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
        // Stall is combinational from EX/MEM, so it must be masked in reset.
        if (reset) mem_stall = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_pc         <= '0;
            r_alu        <= '0;
            r_rd         <= '0;
            r_funct3     <= '0;
            r_memtoreg   <= 1'b0;
            r_regwrite   <= 1'b0;
            r_req_valid  <= 1'b0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_mem_wb     <= '0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op && !w_misaligned) begin
                        r_pc                <= EX_MEM_PC;
                        r_alu               <= EX_MEM_ALUResult;
                        r_rd                <= EX_MEM_Rd;
                        r_funct3            <= EX_MEM_Funct3;
                        r_memtoreg          <= EX_MEM_MemToReg;
                        r_regwrite          <= EX_MEM_RegWrite;
                        r_we                <= EX_MEM_MemWrite;
                        r_wdata             <= w_wdata;
                        r_wstrb             <= w_wstrb;
                        r_req_valid         <= 1'b1;
                        r_count             <= '0;
                        r_mem_wb.enable     <= 1'b0;
                        r_mem_wb.regwrite   <= 1'b0;
                    end else begin
                        // Pass-through; a misaligned memory op retires without
                        // a register write.
                        r_mem_wb.enable     <= EX_MEM_enable_out;
                        r_mem_wb.regwrite   <= EX_MEM_enable_out && EX_MEM_RegWrite && !w_mem_op;
                        r_mem_wb.memtoreg   <= EX_MEM_MemToReg;
                        r_mem_wb.pc         <= EX_MEM_PC;
                        r_mem_wb.alu_result <= EX_MEM_ALUResult;
                        r_mem_wb.rd         <= EX_MEM_Rd;
                        r_mem_wb.read_data  <= '0;
                        r_misaligned        <= w_mem_op;
                    end
                end
                S_REQ, S_WAIT: begin
                    r_count           <= r_count + 16'd1;
                    r_mem_wb.enable   <= 1'b0;
                    r_mem_wb.regwrite <= 1'b0;
                    if (r_state == S_REQ && dmem_req_ready) r_req_valid <= 1'b0;
                    if (w_complete) begin
                        r_mem_wb.enable     <= 1'b1;
                        r_mem_wb.regwrite   <= r_regwrite;
                        r_mem_wb.memtoreg   <= r_memtoreg;
                        r_mem_wb.pc         <= r_pc;
                        r_mem_wb.alu_result <= r_alu;
                        r_mem_wb.rd         <= r_rd;
                        r_mem_wb.read_data  <= r_we ? 32'd0 : w_load_data;
                    end else if (w_timeout) begin
                        r_mem_wb.enable <= 1'b1;
                        r_req_valid     <= 1'b0;
                        r_bus_error     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_req_valid    = r_req_valid;
    assign dmem_addr         = {r_alu[31:2], 2'b00};
    assign dmem_we           = r_we;
    assign dmem_wdata        = r_wdata;
    assign dmem_wstrb        = r_wstrb;
    assign mem_misaligned    = r_misaligned;
    assign mem_bus_error     = r_bus_error;
    assign MEM_WB_enable_out = r_mem_wb.enable;
    assign MEM_WB_MemToReg   = r_mem_wb.memtoreg;
    assign MEM_WB_RegWrite   = r_mem_wb.regwrite;
    assign MEM_WB_PC         = r_mem_wb.pc;
    assign MEM_WB_ALUResult  = r_mem_wb.alu_result;
    assign MEM_WB_ReadData   = r_mem_wb.read_data;
    assign MEM_WB_Rd         = r_mem_wb.rd;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT_CYCLES = 8).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        EX_MEM_enable_out;
    logic [31:0] EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData;
    logic [4:0]  EX_MEM_Rd;
    logic [2:0]  EX_MEM_Funct3;
    logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        mem_stall, mem_misaligned, mem_bus_error;
    logic        MEM_WB_enable_out, MEM_WB_MemToReg, MEM_WB_RegWrite;
    logic [31:0] MEM_WB_PC, MEM_WB_ALUResult, MEM_WB_ReadData;
    logic [4:0]  MEM_WB_Rd;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT_CYCLES(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .EX_MEM_enable_out (EX_MEM_enable_out),
        .EX_MEM_PC         (EX_MEM_PC),
        .EX_MEM_ALUResult  (EX_MEM_ALUResult),
        .EX_MEM_WriteData  (EX_MEM_WriteData),
        .EX_MEM_Rd         (EX_MEM_Rd),
        .EX_MEM_Funct3     (EX_MEM_Funct3),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_MemWrite   (EX_MEM_MemWrite),
        .EX_MEM_MemToReg   (EX_MEM_MemToReg),
        .EX_MEM_RegWrite   (EX_MEM_RegWrite),
        .dmem_req_valid    (dmem_req_valid),
        .dmem_req_ready    (dmem_req_ready),
        .dmem_addr         (dmem_addr),
        .dmem_we           (dmem_we),
        .dmem_wdata        (dmem_wdata),
        .dmem_wstrb        (dmem_wstrb),
        .dmem_rsp_valid    (dmem_rsp_valid),
        .dmem_rdata        (dmem_rdata),
        .mem_stall         (mem_stall),
        .mem_misaligned    (mem_misaligned),
        .mem_bus_error     (mem_bus_error),
        .MEM_WB_enable_out (MEM_WB_enable_out),
        .MEM_WB_MemToReg   (MEM_WB_MemToReg),
        .MEM_WB_RegWrite   (MEM_WB_RegWrite),
        .MEM_WB_PC         (MEM_WB_PC),
        .MEM_WB_ALUResult  (MEM_WB_ALUResult),
        .MEM_WB_ReadData   (MEM_WB_ReadData),
        .MEM_WB_Rd         (MEM_WB_Rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        EX_MEM_enable_out = 1'b0;
        EX_MEM_PC         = '0;
        EX_MEM_ALUResult  = '0;
        EX_MEM_WriteData  = '0;
        EX_MEM_Rd         = '0;
        EX_MEM_Funct3     = '0;
        EX_MEM_MemRead    = 1'b0;
        EX_MEM_MemWrite   = 1'b0;
        EX_MEM_MemToReg   = 1'b0;
        EX_MEM_RegWrite   = 1'b0;
    endtask

    task automatic set_op(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] rd, input logic [2:0] f3, input logic rd_en,
                          input logic wr_en, input logic m2r, input logic rw);
        EX_MEM_enable_out = 1'b1;
        EX_MEM_PC         = pc;
        EX_MEM_ALUResult  = alu;
        EX_MEM_WriteData  = wd;
        EX_MEM_Rd         = rd;
        EX_MEM_Funct3     = f3;
        EX_MEM_MemRead    = rd_en;
        EX_MEM_MemWrite   = wr_en;
        EX_MEM_MemToReg   = m2r;
        EX_MEM_RegWrite   = rw;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_ex();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rdata     = '0;

        // Reset state
        tick();
        tick();
        check("rst_req_valid", dmem_req_valid, 0);
        check("rst_we", dmem_we, 0);
        check("rst_wstrb", dmem_wstrb, 0);
        check("rst_wb_en", MEM_WB_enable_out, 0);
        check("rst_wb_rw", MEM_WB_RegWrite, 0);
        check("rst_stall", mem_stall, 0);
        reset = 1'b0;

        // ALU op passes through in one cycle
        set_op(32'h40, 32'h1234, 32'h0, 5'd5, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("alu_stall", mem_stall, 0);
        tick();
        check("alu_result", MEM_WB_ALUResult, 32'h1234);
        check("alu_rw", MEM_WB_RegWrite, 1);
        check("alu_en", MEM_WB_enable_out, 1);
        check("alu_rd", MEM_WB_Rd, 5);
        check("alu_pc", MEM_WB_PC, 32'h40);
        clear_ex();
        tick();
        check("bubble_en", MEM_WB_enable_out, 0);
        check("bubble_rw", MEM_WB_RegWrite, 0);

        // LB at 0x103, ready in first REQ cycle, response in second WAIT cycle
        set_op(32'h50, 32'h103, 32'h0, 5'd7, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        check("lb_stall_idle", mem_stall, 1);
        tick();
        check("lb_req_valid", dmem_req_valid, 1);
        check("lb_addr", dmem_addr, 32'h100);
        check("lb_wstrb", dmem_wstrb, 0);
        check("lb_we", dmem_we, 0);
        check("lb_wb_bubble", MEM_WB_enable_out, 0);
        dmem_req_ready = 1'b1;
        #1;
        check("lb_stall_req", mem_stall, 1);
        tick();
        dmem_req_ready = 1'b0;
        #1;
        check("lb_wait_req_valid", dmem_req_valid, 0);
        check("lb_stall_wait", mem_stall, 1);
        tick();
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 32'h80FF_0000;
        #1;
        check("lb_stall_done", mem_stall, 0);
        tick();
        dmem_rsp_valid = 1'b0;
        clear_ex();
        #1;
        check("lb_rdata", MEM_WB_ReadData, 32'hFFFF_FF80);
        check("lb_en", MEM_WB_enable_out, 1);
        check("lb_rw", MEM_WB_RegWrite, 1);
        check("lb_rd", MEM_WB_Rd, 7);
        check("lb_m2r", MEM_WB_MemToReg, 1);
        check("lb_stall_after", mem_stall, 0);

        // SH at 0x202 with ready held low 4 cycles
        set_op(32'h60, 32'h202, 32'hAAAA_BEEF, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("sh_stall_idle", mem_stall, 1);
        tick();
        check("sh_wstrb", dmem_wstrb, 4'b1100);
        check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        check("sh_we", dmem_we, 1);
        check("sh_addr", dmem_addr, 32'h200);
        for (int i = 0; i < 4; i++) begin
            check("sh_hold_valid", dmem_req_valid, 1);
            check("sh_hold_stall", mem_stall, 1);
            tick();
        end
        check("sh_valid_at_ready", dmem_req_valid, 1);
        check("sh_wdata_stable", dmem_wdata, 32'hBEEF_BEEF);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b1;
        #1;
        check("sh_wait_valid", dmem_req_valid, 0);
        check("sh_stall_done", mem_stall, 0);
        tick();
        dmem_rsp_valid = 1'b0;
        clear_ex();
        check("sh_en", MEM_WB_enable_out, 1);
        check("sh_rw", MEM_WB_RegWrite, 0);
        check("sh_rdata", MEM_WB_ReadData, 0);

        // Misaligned LW at 0x301
        set_op(32'h70, 32'h301, 32'h0, 5'd9, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        check("lw_mis_stall", mem_stall, 0);
        tick();
        clear_ex();
        check("lw_mis_req", dmem_req_valid, 0);
        check("lw_mis_pulse", mem_misaligned, 1);
        check("lw_mis_en", MEM_WB_enable_out, 1);
        check("lw_mis_rw", MEM_WB_RegWrite, 0);
        tick();
        check("lw_mis_pulse_end", mem_misaligned, 0);
        check("lw_mis_req_after", dmem_req_valid, 0);

        // Timeout: ready=1, no response
        set_op(32'h80, 32'h400, 32'h0, 5'd4, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        for (int i = 1; i < 7; i++) begin
            check("to_stall", mem_stall, 1);
            check("to_no_err", mem_bus_error, 0);
            tick();
        end
        check("to_stall_abort", mem_stall, 0);
        tick();
        check("to_bus_err", mem_bus_error, 1);
        check("to_en", MEM_WB_enable_out, 1);
        check("to_rw", MEM_WB_RegWrite, 0);
        check("to_req_valid", dmem_req_valid, 0);
        set_op(32'h84, 32'hABCD, 32'h0, 5'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("post_to_stall", mem_stall, 0);
        tick();
        clear_ex();
        check("post_to_err_end", mem_bus_error, 0);
        check("post_to_alu", MEM_WB_ALUResult, 32'hABCD);
        check("post_to_rw", MEM_WB_RegWrite, 1);

        // Reset during WAIT of a SW; late response must be ignored
        set_op(32'h90, 32'h500, 32'h1122_3344, 5'd0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("sw_wstrb", dmem_wstrb, 4'b1111);
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        check("sw_we_wait", dmem_we, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_req_valid", dmem_req_valid, 0);
        check("mid_rst_we", dmem_we, 0);
        check("mid_rst_wstrb", dmem_wstrb, 0);
        check("mid_rst_stall", mem_stall, 0);
        check("mid_rst_wb_en", MEM_WB_enable_out, 0);
        tick();
        reset = 1'b0;
        clear_ex();
        tick();
        dmem_rsp_valid = 1'b1;
        #1;
        check("late_rsp_stall", mem_stall, 0);
        tick();
        dmem_rsp_valid = 1'b0;
        check("late_rsp_en", MEM_WB_enable_out, 0);
        check("late_rsp_rw", MEM_WB_RegWrite, 0);
        check("late_rsp_req", dmem_req_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
